dmem_responder: RTL and testbench

//  Memory-side responder for the pipeline's data-memory port: accepts dmem_addr/rmask/wmask/wdata

---
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency, byte-maskable data-memory responder for the pipeline dmem port
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         DIRECT = (LATENCY == 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:2] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_rmask, cap_wmask;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic        req, accept, drop, req_bad;
  logic        enter_resp, use_live;
  logic [31:2] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_rmask, op_wmask;
  logic        op_bad, op_is_write;
  logic [ADDR_W-1:0] op_idx;
  logic        addr_lsb_unused;

  // Byte offset is meaningless for a word-organised store; masks already carry lane intent.
  assign addr_lsb_unused = ^dmem_addr[1:0];

  assign req     = (|dmem_rmask) | (|dmem_wmask);
  assign accept  = req && (state != S_WAIT);
  assign drop    = req && (state == S_WAIT);
  assign req_bad = ((|dmem_rmask) && (|dmem_wmask)) || (|dmem_addr[31:ADDR_W+2]);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req) state_nxt = DIRECT ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  if (req) state_nxt = DIRECT ? S_RESP : S_WAIT;
               else     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY==1 the RESP edge is the accept edge, so the operation comes straight off the port.
  assign enter_resp = (state_nxt == S_RESP);
  assign use_live   = (state != S_WAIT);
  assign op_addr    = use_live ? dmem_addr[31:2] : cap_addr;
  assign op_wdata   = use_live ? dmem_wdata      : cap_wdata;
  assign op_rmask   = use_live ? dmem_rmask      : cap_rmask;
  assign op_wmask   = use_live ? dmem_wmask      : cap_wmask;
  assign op_idx      = op_addr[ADDR_W+1:2];
  assign op_is_write = |op_wmask;
  assign op_bad      = ((|op_rmask) && op_is_write) || (|op_addr[31:ADDR_W+2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_rmask  <= '0;
      cap_wmask  <= '0;
      dmem_rdata <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_addr  <= dmem_addr[31:2];
        cap_wdata <= dmem_wdata;
        cap_rmask <= dmem_rmask;
        cap_wmask <= dmem_wmask;
        cnt       <= LAT_M1;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (drop || (accept && req_bad)) err <= 1'b1;
      if (enter_resp) dmem_rdata <= (op_bad || op_is_write) ? 32'h0 : mem[op_idx];
    end
  end

  // Storage keeps its contents across reset; writes are only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && op_is_write && !op_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wmask[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    dmem_resp = (state == S_RESP);
    busy      = (state == S_WAIT);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - random + directed bench for dmem_responder at latencies 1..4
module tb_dmem_responder;

  localparam int NI  = 4;
  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  r;
    logic [3:0]  w;
    bit          done;
    logic [31:0] rd;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  rmask = '0, wmask = '0;
  logic [31:0] rd_w   [NI];
  logic        resp_w [NI];
  logic        busy_w [NI];
  logic        err_w  [NI];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .dmem_addr(addr),
    .dmem_rmask(rmask), .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd_w[0]),
    .dmem_resp(resp_w[0]), .busy(busy_w[0]), .err(err_w[0]));
  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .dmem_addr(addr),
    .dmem_rmask(rmask), .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd_w[1]),
    .dmem_resp(resp_w[1]), .busy(busy_w[1]), .err(err_w[1]));
  dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .dmem_addr(addr),
    .dmem_rmask(rmask), .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd_w[2]),
    .dmem_resp(resp_w[2]), .busy(busy_w[2]), .err(err_w[2]));
  dmem_responder #(.ADDR_W(10), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .dmem_addr(addr),
    .dmem_rmask(rmask), .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd_w[3]),
    .dmem_resp(resp_w[3]), .busy(busy_w[3]), .err(err_w[3]));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_m [NI][1024];
  pend_t       last_p [NI];
  pend_t       prev_p [NI];
  logic [31:0] hold_rd [NI];
  int          err_from [NI];
  bit          in_rst = 1'b1;

  int          obs_cnt  [NI];
  int          obs_last [NI];
  logic [31:0] obs_rd   [NI];
  logic [95:0] obs3     [NI];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exec(int k, bit lst);
    pend_t p;
    int    idx;
    p = lst ? last_p[k] : prev_p[k];
    if (p.due < 0 || p.done) return;
    p.done = 1'b1;
    p.rd   = 32'h0;
    if (p.a[31:12] == 20'h0 && !(p.r != 0 && p.w != 0)) begin
      idx = int'(p.a[11:2]);
      if (p.w != 0) begin
        for (int b = 0; b < 4; b++)
          if (p.w[b]) mem_m[k][idx][8*b +: 8] = p.d[8*b +: 8];
      end else begin
        p.rd = mem_m[k][idx];
      end
    end
    if (lst) last_p[k] = p; else prev_p[k] = p;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      last_p[k].due = -1; last_p[k].acc = -1; last_p[k].done = 1'b1;
      prev_p[k].due = -1; prev_p[k].acc = -1; prev_p[k].done = 1'b1;
      hold_rd[k]  = 32'h0;
      err_from[k] = BIG;
    end
  endtask

  // Ops whose response edge already happened took effect; anything later is lost.
  task automatic model_reset(int r);
    for (int k = 0; k < NI; k++) begin
      if (prev_p[k].due >= 0 && prev_p[k].due <= r) exec(k, 1'b0);
      if (last_p[k].due >= 0 && last_p[k].due <= r) exec(k, 1'b1);
    end
    model_clear();
  endtask

  task automatic model_req(int t, logic [31:0] a, logic [3:0] r, logic [3:0] w, logic [31:0] d);
    pend_t p;
    if (r == 0 && w == 0) return;
    for (int k = 0; k < NI; k++) begin
      if (t < last_p[k].due) begin
        if (err_from[k] > t + 1) err_from[k] = t + 1;
      end else begin
        if ((a[31:12] != 0) || (r != 0 && w != 0))
          if (err_from[k] > t + 1) err_from[k] = t + 1;
        exec(k, 1'b0);
        exec(k, 1'b1);
        p.acc = t; p.due = t + k + 1; p.a = a; p.d = d; p.r = r; p.w = w;
        p.done = 1'b0; p.rd = 32'h0;
        prev_p[k] = last_p[k];
        last_p[k] = p;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit exp_resp, exp_busy, exp_err;
      if (in_rst) begin
        chk($sformatf("rst_resp[L%0d]", k + 1), 32'(resp_w[k]), 32'h0);
        chk($sformatf("rst_busy[L%0d]", k + 1), 32'(busy_w[k]), 32'h0);
        chk($sformatf("rst_err[L%0d]",  k + 1), 32'(err_w[k]),  32'h0);
        chk($sformatf("rst_rdata[L%0d]", k + 1), rd_w[k], 32'h0);
      end else begin
        exp_resp = (prev_p[k].due == cyc) || (last_p[k].due == cyc);
        if (exp_resp) begin
          exec(k, 1'b0);
          if (last_p[k].due == cyc) exec(k, 1'b1);
          hold_rd[k] = (last_p[k].due == cyc) ? last_p[k].rd : prev_p[k].rd;
        end
        exp_busy = (last_p[k].acc >= 0) && (last_p[k].acc < cyc) && (cyc < last_p[k].due);
        exp_err  = (cyc >= err_from[k]);
        chk($sformatf("resp[L%0d]",  k + 1), 32'(resp_w[k]), 32'(exp_resp));
        chk($sformatf("busy[L%0d]",  k + 1), 32'(busy_w[k]), 32'(exp_busy));
        chk($sformatf("err[L%0d]",   k + 1), 32'(err_w[k]),  32'(exp_err));
        chk($sformatf("rdata[L%0d]", k + 1), rd_w[k], hold_rd[k]);
      end
      if (resp_w[k] === 1'b1) begin
        obs_cnt[k]++;
        obs_last[k] = cyc;
        obs_rd[k]   = rd_w[k];
        obs3[k]     = {obs3[k][63:0], rd_w[k]};
      end
    end
  end

  task automatic step(logic [31:0] a, logic [3:0] r, logic [3:0] w, logic [31:0] d);
    addr = a; rmask = r; wmask = w; wdata = d;
    model_req(cyc, a, r, w, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(32'h0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic reset_pulse(int n);
    addr = '0; rmask = '0; wmask = '0; wdata = '0;
    in_rst = 1'b1;
    model_reset(cyc);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    int t, c;
    logic [31:0] a;
    logic [3:0]  r, w;
    model_clear();
    for (int k = 0; k < NI; k++) begin
      obs_cnt[k] = 0; obs_last[k] = -1; obs_rd[k] = '0; obs3[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      step(32'(i * 4), 4'h0, 4'hF, 32'(i + 1));
      idle(3);
    end

    t = cyc;
    step(32'h40, 4'h0, 4'hF, 32'hDEAD_BEEF);
    idle(3);
    chk("t1_wr_latency", 32'(obs_last[1]), 32'(t + 2));
    t = cyc;
    step(32'h40, 4'hF, 4'h0, 32'h0);
    idle(3);
    chk("t1_rd_latency", 32'(obs_last[1]), 32'(t + 2));
    chk("t1_rd_data", obs_rd[1], 32'hDEAD_BEEF);
    chk("t1_err", 32'(err_w[1]), 32'h0);

    step(32'h40, 4'h0, 4'b0100, 32'h00AA_0000);
    idle(3);
    step(32'h40, 4'hF, 4'h0, 32'h0);
    idle(3);
    chk("t2_byte_mask", obs_rd[1], 32'hDEAA_BEEF);

    c = obs_cnt[0];
    t = cyc;
    step(32'h0, 4'hF, 4'h0, 32'h0);
    step(32'h4, 4'hF, 4'h0, 32'h0);
    step(32'h8, 4'hF, 4'h0, 32'h0);
    idle(4);
    chk("t3_resp_count", 32'(obs_cnt[0] - c), 32'd3);
    chk("t3_last_resp", 32'(obs_last[0]), 32'(t + 3));
    chk("t3_order", obs3[0][31:0], 32'd3);
    chk("t3_order_mid", obs3[0][63:32], 32'd2);
    chk("t3_order_first", obs3[0][95:64], 32'd1);

    reset_pulse(2);
    step(32'h10, 4'hF, 4'hF, 32'h1234_5678);
    idle(4);
    chk("t4_conflict_err", 32'(err_w[2]), 32'h1);
    step(32'h10, 4'hF, 4'h0, 32'h0);
    idle(4);
    chk("t4_mem_unchanged", obs_rd[2], 32'd5);

    reset_pulse(2);
    c = obs_cnt[2];
    step(32'h40, 4'hF, 4'h0, 32'h0);
    step(32'h44, 4'hF, 4'h0, 32'h0);
    idle(4);
    chk("t4_drop_one_resp", 32'(obs_cnt[2] - c), 32'd1);
    chk("t4_drop_err", 32'(err_w[2]), 32'h1);

    reset_pulse(2);
    t = cyc;
    step(32'h0000_1000, 4'hF, 4'h0, 32'h0);
    idle(3);
    chk("t5_oob_latency", 32'(obs_last[1]), 32'(t + 2));
    chk("t5_oob_rdata", obs_rd[1], 32'h0);
    chk("t5_oob_err", 32'(err_w[1]), 32'h1);

    reset_pulse(2);
    c = obs_cnt[3];
    step(32'h20, 4'hF, 4'h0, 32'h0);
    idle(1);
    in_rst = 1'b1;
    model_reset(cyc);
    rst = 1'b0;
    #1;
    chk("t6_rst_resp", 32'(resp_w[3]), 32'h0);
    chk("t6_rst_busy", 32'(busy_w[3]), 32'h0);
    chk("t6_rst_rdata", rd_w[3], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b0;
    idle(8);
    chk("t6_no_stale_resp", 32'(obs_cnt[3] - c), 32'd0);
    step(32'h40, 4'hF, 4'h0, 32'h0);
    idle(5);
    chk("t6_retained", obs_rd[3], 32'hDEAA_BEEF);
    chk("t6_one_resp", 32'(obs_cnt[3] - c), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse(int'($urandom_range(1, 2)));
      end else begin
        a = {20'h0, 5'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
        if ($urandom_range(0, 99) < 8) a = $urandom | 32'h0000_1000;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin r = 4'h0; w = 4'h0; end
          4, 5:       begin r = 4'($urandom_range(1, 15)); w = 4'h0; end
          6, 7, 8:    begin r = 4'h0; w = 4'($urandom_range(1, 15)); end
          default:    begin r = 4'($urandom_range(1, 15)); w = 4'($urandom_range(1, 15)); end
        endcase
        step(a, r, w, $urandom);
      end
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
